systolic_array_nxn: RTL and testbench
=====================================

Name: systolic_array_nxn

Overview:
Parametrised N x N output-stationary systolic matrix-multiply engine, successor to the fixed 3x3 array. It computes C = A x B over a streamed inner dimension K of arbitrary length. Input skew, valid tagging, a job FSM and a held, back-pressured result interface are all internal. It sits between the operand stream source and the result consumer.

Parameters:
N, 4, array dimension (rows = cols = N); legal range 2..16
DATA_W, 8, operand width
ACC_W, 2*DATA_W+4, accumulator/result width; results wrap modulo 2^ACC_W
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, sign-extended products

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
a_in  in  N*DATA_W  beat k: column k of A; row i at [i*DATA_W +: DATA_W]
b_in  in  N*DATA_W  beat k: row k of B; column j at [j*DATA_W +: DATA_W]
in_valid  in  1  beat present
in_last  in  1  marks final beat of the job; qualified by in_valid
in_ready  out  1  block accepts beats
c_out  out  N*N*ACC_W  C[i][j] at [(i*N+j)*ACC_W +: ACC_W]; row-major
out_valid  out  1  c_out holds a complete result
out_ready  in  1  consumer accepts result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): all skew stages, PE operand/valid regs and accumulators = 0; state = IDLE; in_ready=1, out_valid=0, busy=0, c_out=0. Deassertion mid-job abandons the job; no partial result is ever presented.
- Accept = in_valid & in_ready. in_ready = (state==IDLE || state==LOAD), combinational from state.
- Skew: row-i A operand and column-j B operand are delayed i and j cycles respectively. Each delay stage carries a valid bit with the data. Non-accepted cycles inject valid=0 bubbles.
- PE(i,j): registers a east and b south with their valid bits, one cycle per hop. Accumulate only when the incoming a-valid & b-valid are both set (they always coincide). Otherwise acc holds. Multiply DATA_W x DATA_W -> 2*DATA_W (signed if SIGNED=1), extend to ACC_W, add, wrap.
- Timing: a beat accepted at edge t is accumulated in PE(i,j) at edge t+i+j+1. The last PE updates at t+2N-1.
- FSM:
  IDLE: accept -> LOAD, or -> FLUSH if in_last.
  LOAD: accept with in_last -> FLUSH; else stay. Bubbles allowed.
  FLUSH: in_ready=0; counter runs 2N-1 cycles from the last-beat edge, then -> DONE.
  DONE: out_valid=1, c_out = accumulators, stable while out_ready=0. out_valid & out_ready -> all accumulators cleared, state IDLE on the same edge.
- out_valid rises exactly 2N cycles after the edge that accepted the last beat (N=4: 8 cycles).
- in_last without in_valid is ignored.
- K=1 (first beat carries in_last) is legal.
- No new beat is accepted in FLUSH/DONE; a beat may be accepted on the cycle after the result handshake.
- c_out is the accumulator array in every state; consumers qualify it with out_valid only.
- Overflow wraps silently; no saturation, no flag.

Test Plan:
- Identity: N=4, A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, 4 beats, no bubbles -> out_valid 8 cycles after the 4th beat; c_out = B.
- Bubbles: same job with in_valid low 3 cycles between every beat -> identical c_out; in_ready stays 1 throughout LOAD.
- Backpressure: out_ready held 0 for 20 cycles -> out_valid and c_out stable, in_ready=0. Pulse out_ready -> next cycle out_valid=0, busy=0, accumulators 0. A second job (A=all 2, B=all 3, K=4) -> every C = 24, with no residue from the first job.
- Wrap: N=2, DATA_W=8, ACC_W=16, SIGNED=0, 2 beats of all 255 -> every C = 130050 mod 65536 = 64514.
- Signed: N=4, SIGNED=1, K=1, a row0=-1, b col0=3, a row1=-128, b col1=-128 -> C[0][0]=0xFFFFD (20-bit), C[1][1]=16384, C[0][1]=128.
- Reset mid-FLUSH: assert rst_n=0 three cycles after the last beat -> outputs 0 immediately (asynchronous). After release, K=1 job (a=all 1, b=all 1) -> every C = 1.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: N x N output-stationary systolic matrix multiplier.
// Each accepted beat carries one column of A and one row of B; the array
// accumulates C = A x B over any number of beats. The finished result is
// held on c_out until the consumer takes it with out_valid & out_ready.
module systolic_array_nxn #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+4,
    parameter int SIGNED = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N*DATA_W-1:0]      a_in,
    input  logic [N*DATA_W-1:0]      b_in,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [N*N*ACC_W-1:0]     c_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int PROD_W     = 2*DATA_W;
    // The far corner PE sees the last beat 2N-1 edges after it was accepted.
    localparam int FLUSH_LAST = 2*N-1;
    localparam int CNT_W      = $clog2(2*N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               accept;
    logic               clear_acc;

    // Skew lines: row i of A uses stages 0..i, column j of B uses 0..j.
    // Stage 0 is the input register shared by every row/column.
    logic [DATA_W-1:0]  a_skew_q   [N][N];
    logic               a_skew_v_q [N][N];
    logic [DATA_W-1:0]  b_skew_q   [N][N];
    logic               b_skew_v_q [N][N];

    // PE pipeline registers: a travels east, b travels south.
    logic [DATA_W-1:0]  pe_a_q     [N][N];
    logic               pe_a_v_q   [N][N];
    logic [DATA_W-1:0]  pe_b_q     [N][N];
    logic               pe_b_v_q   [N][N];
    logic [ACC_W-1:0]   acc_q      [N][N];

    // Operands arriving at each PE this cycle, and the accumulator next state.
    logic [DATA_W-1:0]  a_west     [N][N];
    logic               a_west_v   [N][N];
    logic [DATA_W-1:0]  b_north    [N][N];
    logic               b_north_v  [N][N];
    logic [ACC_W-1:0]   acc_d      [N][N];

    // Product of two operands, extended to the accumulator width. The
    // operands are widened first so the multiply is exact modulo 2^PROD_W
    // in both signed and unsigned modes.
    function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [PROD_W-1:0] ax;
        logic [PROD_W-1:0] bx;
        logic [PROD_W-1:0] p;
        logic [ACC_W-1:0]  r;
        if (SIGNED != 0) begin
            ax = {{DATA_W{a[DATA_W-1]}}, a};
            bx = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            ax = {{DATA_W{1'b0}}, a};
            bx = {{DATA_W{1'b0}}, b};
        end
        p = ax * bx;
        r = ((SIGNED != 0) && p[PROD_W-1]) ? '1 : '0;
        r[PROD_W-1:0] = p;
        return r;
    endfunction

    // Beats are only taken while a job is open and not yet flushing.
    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept    = in_valid & in_ready;
    // The result handshake empties the array for the next job.
    assign clear_acc = (state_q == S_DONE) && out_ready;

    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Job sequencing: collect beats, wait for the wavefront to drain, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q <= in_last ? S_FLUSH : S_LOAD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept && in_last) begin
                        state_q <= S_FLUSH;
                        cnt_q   <= '0;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == CNT_W'(FLUSH_LAST)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Input register plus per-row/per-column delay lines; idle cycles
    // travel through as valid=0 bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int s = 0; s < N; s++) begin
                    a_skew_q[i][s]   <= '0;
                    a_skew_v_q[i][s] <= 1'b0;
                    b_skew_q[i][s]   <= '0;
                    b_skew_v_q[i][s] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                a_skew_q[i][0]   <= a_in[i*DATA_W +: DATA_W];
                a_skew_v_q[i][0] <= accept;
                b_skew_q[i][0]   <= b_in[i*DATA_W +: DATA_W];
                b_skew_v_q[i][0] <= accept;
                for (int s = 1; s < N; s++) begin
                    a_skew_q[i][s]   <= a_skew_q[i][s-1];
                    a_skew_v_q[i][s] <= a_skew_v_q[i][s-1];
                    b_skew_q[i][s]   <= b_skew_q[i][s-1];
                    b_skew_v_q[i][s] <= b_skew_v_q[i][s-1];
                end
            end
        end
    end

    // Per-PE operand routing, multiply-accumulate and result packing.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            for (genvar gj = 0; gj < N; gj++) begin : g_col
                if (gj == 0) begin : g_a_edge
                    assign a_west[gi][gj]   = a_skew_q[gi][gi];
                    assign a_west_v[gi][gj] = a_skew_v_q[gi][gi];
                end else begin : g_a_inner
                    assign a_west[gi][gj]   = pe_a_q[gi][gj-1];
                    assign a_west_v[gi][gj] = pe_a_v_q[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_north[gi][gj]   = b_skew_q[gj][gj];
                    assign b_north_v[gi][gj] = b_skew_v_q[gj][gj];
                end else begin : g_b_inner
                    assign b_north[gi][gj]   = pe_b_q[gi-1][gj];
                    assign b_north_v[gi][gj] = pe_b_v_q[gi-1][gj];
                end

                // Both valids always arrive together; requiring both keeps
                // a stray bubble from ever touching the accumulator.
                assign acc_d[gi][gj] =
                    clear_acc ? '0 :
                    (a_west_v[gi][gj] && b_north_v[gi][gj]) ?
                        acc_q[gi][gj] + mac_term(a_west[gi][gj], b_north[gi][gj]) :
                        acc_q[gi][gj];

                assign c_out[(gi*N+gj)*ACC_W +: ACC_W] = acc_q[gi][gj];
            end
        end
    endgenerate

    // PE registers: forward operands one hop per cycle and update accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pe_a_q[i][j]   <= '0;
                    pe_a_v_q[i][j] <= 1'b0;
                    pe_b_q[i][j]   <= '0;
                    pe_b_v_q[i][j] <= 1'b0;
                    acc_q[i][j]    <= '0;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pe_a_q[i][j]   <= a_west[i][j];
                    pe_a_v_q[i][j] <= a_west_v[i][j];
                    pe_b_q[i][j]   <= b_north[i][j];
                    pe_b_v_q[i][j] <= b_north_v[i][j];
                    acc_q[i][j]    <= acc_d[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb_systolic_array_nxn: three systolic arrays (4x4 unsigned, 4x4 signed,
// 2x2 unsigned with a 16-bit accumulator) share one operand stream. The
// 2x2 array sees rows/columns 0..1 only, so it computes the top-left
// corner of the same product.
module tb_systolic_array_nxn;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  a_in;
    logic [31:0]  b_in;
    logic         in_valid;
    logic         in_last;
    logic         out_ready;

    logic         rdy_u, rdy_s, rdy_2;
    logic         ov_u,  ov_s,  ov_2;
    logic         bz_u,  bz_s,  bz_2;
    logic [319:0] c_u;
    logic [319:0] c_s;
    logic [63:0]  c_2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    systolic_array_nxn #(.N(4), .DATA_W(8), .ACC_W(20), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_u),
        .c_out(c_u), .out_valid(ov_u), .out_ready(out_ready), .busy(bz_u)
    );

    systolic_array_nxn #(.N(4), .DATA_W(8), .ACC_W(20), .SIGNED(1)) u_sdut (
        .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_s),
        .c_out(c_s), .out_valid(ov_s), .out_ready(out_ready), .busy(bz_s)
    );

    systolic_array_nxn #(.N(2), .DATA_W(8), .ACC_W(16), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a_in(a_in[15:0]), .b_in(b_in[15:0]),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_2),
        .c_out(c_2), .out_valid(ov_2), .out_ready(out_ready), .busy(bz_2)
    );

    // ---------------- behavioural model ----------------
    // Each instance keeps the list of beats of its open job with the edge
    // that accepted them. PE(i,j) has absorbed beat k once edge t_k+i+j+1
    // has passed; the result is valid from edge t_last+2N until handshake.
    int          ecnt = 0;
    int          nb [3];
    int          bt [3][64];
    logic [7:0]  ba [3][64][4];
    logic [7:0]  bb [3][64][4];
    bit          seen_last [3];
    int          t_last [3];
    bit          started [3];
    bit          hs [3];
    bit          ac [3];

    function automatic int n_of(int m);
        return (m == 2) ? 2 : 4;
    endfunction

    function automatic bit m_valid(int m);
        return seen_last[m] && (ecnt >= t_last[m] + 2*n_of(m));
    endfunction

    function automatic longint term(int m, logic [7:0] a, logic [7:0] b);
        if (m == 1) return longint'($signed(a)) * longint'($signed(b));
        return longint'(a) * longint'(b);
    endfunction

    function automatic logic [319:0] exp_c(int m);
        logic [319:0] v;
        longint       s;
        int           n;
        v = '0;
        n = n_of(m);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < nb[m]; k++)
                    if (bt[m][k] + i + j + 1 <= ecnt)
                        s += term(m, ba[m][k][i], bb[m][k][j]);
                if (m == 2) v[(i*2+j)*16 +: 16] = s[15:0];
                else        v[(i*4+j)*20 +: 20] = s[19:0];
            end
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 3; m++) begin
            nb[m] = 0;
            seen_last[m] = 1'b0;
            started[m] = 1'b0;
            t_last[m] = 0;
        end
    endtask

    always @(negedge rst_n) model_clear();

    // Model advance on every active edge, using bench-driven inputs only.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 3; m++) begin
                hs[m] = m_valid(m) && out_ready;
                ac[m] = in_valid && !seen_last[m] && !hs[m];
            end
            ecnt = ecnt + 1;
            for (int m = 0; m < 3; m++) begin
                if (hs[m]) begin
                    nb[m] = 0;
                    seen_last[m] = 1'b0;
                    started[m] = 1'b0;
                end else if (ac[m] && nb[m] < 64) begin
                    bt[m][nb[m]] = ecnt;
                    for (int r = 0; r < 4; r++) begin
                        ba[m][nb[m]][r] = a_in[r*8 +: 8];
                        bb[m][nb[m]][r] = b_in[r*8 +: 8];
                    end
                    nb[m] = nb[m] + 1;
                    started[m] = 1'b1;
                    if (in_last) begin
                        seen_last[m] = 1'b1;
                        t_last[m] = ecnt;
                    end
                end
            end
        end
    end

    task automatic cmp(string nm, int m, logic [319:0] act, logic [319:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", nm, m, ecnt, act, expv);
        end
    endtask

    logic [319:0] g_c;
    logic         g_r, g_v, g_b;

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        for (int m = 0; m < 3; m++) begin
            case (m)
                0:       begin g_c = c_u; g_r = rdy_u; g_v = ov_u; g_b = bz_u; end
                1:       begin g_c = c_s; g_r = rdy_s; g_v = ov_s; g_b = bz_s; end
                default: begin g_c = {256'd0, c_2}; g_r = rdy_2; g_v = ov_2; g_b = bz_2; end
            endcase
            cmp("in_ready",  m, {319'd0, g_r}, {319'd0, !seen_last[m]});
            cmp("out_valid", m, {319'd0, g_v}, {319'd0, m_valid(m)});
            cmp("busy",      m, {319'd0, g_b}, {319'd0, started[m]});
            cmp("c_out",     m, g_c, exp_c(m));
        end
    end

    // ---------------- literal expectations ----------------
    task automatic check_lit(string nm, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] get_u(int i, int j);
        return 32'(c_u[(i*4+j)*20 +: 20]);
    endfunction
    function automatic logic [31:0] get_s(int i, int j);
        return 32'(c_s[(i*4+j)*20 +: 20]);
    endfunction
    function automatic logic [31:0] get_2(int i, int j);
        return 32'(c_2[(i*2+j)*16 +: 16]);
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(logic [31:0] a, logic [31:0] b, bit last);
        in_valid = 1'b1;
        in_last  = last;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Identity A with B = 1..16 row-major; idle gaps carry a stray in_last.
    task automatic ident_job(int gap);
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < 4; k++) begin
            a = 32'h1 << (8*k);
            b = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
            send(a, b, k == 3);
            if (k != 3) begin
                for (int g = 0; g < gap; g++) begin
                    in_last = 1'b1;
                    @(negedge clk);
                    in_last = 1'b0;
                    check_lit("gap_in_ready", 32'(rdy_u), 1);
                end
            end
        end
    endtask

    task automatic wait_valid(string nm, int exp_lat);
        int lat;
        lat = 0;
        while (ov_u !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_lit(nm, lat, exp_lat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_lit("hs_out_valid", 32'(ov_u), 0);
        check_lit("hs_busy", 32'(bz_u), 0);
        check_lit("hs_acc_nonzero", 32'(c_u != '0), 0);
    endtask

    task automatic check_ident();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check_lit("ident_c", get_u(i, j), 4*i+j+1);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                check_lit("ident_c2", get_2(i, j), 4*i+j+1);
    endtask

    task automatic check_all(string nm, logic [31:0] vu, logic [31:0] v2);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check_lit(nm, get_u(i, j), vu);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                check_lit(nm, get_2(i, j), v2);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("rst_in_ready", 32'(rdy_u), 1);
        check_lit("rst_out_valid", 32'(ov_u), 0);
        check_lit("rst_busy", 32'(bz_u), 0);
        check_lit("rst_c_nonzero", 32'(c_u != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity, back-to-back beats.
        ident_job(0);
        wait_valid("latency_ident", 8);
        check_ident();
        handshake();

        // Same job with 3-cycle bubbles between beats.
        ident_job(3);
        wait_valid("latency_bubbles", 8);
        check_ident();
        handshake();

        // Result held under backpressure.
        ident_job(0);
        wait_valid("latency_bp", 8);
        repeat (20) @(negedge clk);
        check_lit("bp_out_valid", 32'(ov_u), 1);
        check_lit("bp_in_ready", 32'(rdy_u), 0);
        check_ident();
        handshake();

        // Second job straight after the handshake: 4 * 2 * 3 = 24 everywhere.
        for (int k = 0; k < 4; k++) send(32'h02020202, 32'h03030303, k == 3);
        wait_valid("latency_job2", 8);
        check_all("job2_c", 24, 24);
        handshake();

        // Two beats of 255: 130050 fits 20 bits, wraps to 64514 in 16 bits.
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_valid("latency_wrap2", 8);
        check_all("wrap2_c", 130050, 64514);
        handshake();

        // 17 beats of 255: 1105425 wraps to 56849 in both widths.
        for (int k = 0; k < 17; k++) send(32'hFFFFFFFF, 32'hFFFFFFFF, k == 16);
        wait_valid("latency_wrap17", 8);
        check_all("wrap17_c", 56849, 56849);
        handshake();

        // K=1 signed products: a = {-1,-128,0,0}, b = {3,-128,0,0}.
        send(32'h000080FF, 32'h00008003, 1'b1);
        wait_valid("latency_k1", 8);
        check_lit("s_c00", get_s(0, 0), 32'hFFFFD);
        check_lit("s_c11", get_s(1, 1), 16384);
        check_lit("s_c01", get_s(0, 1), 128);
        check_lit("s_c10", get_s(1, 0), 32'hFFE80);
        check_lit("u_c00", get_u(0, 0), 765);
        check_lit("u_c01", get_u(0, 1), 32640);
        handshake();

        // Reset three edges after the last beat, while flushing.
        ident_job(0);
        repeat (3) @(posedge clk);
        #2;
        check_lit("pre_rst_c00", get_u(0, 0), 1);
        rst_n = 1'b0;
        #1;
        check_lit("arst_c_nonzero", 32'(c_u != '0), 0);
        check_lit("arst_c2_nonzero", 32'(c_2 != '0), 0);
        check_lit("arst_out_valid", 32'(ov_u), 0);
        check_lit("arst_busy", 32'(bz_u), 0);
        check_lit("arst_in_ready", 32'(rdy_u), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'h01010101, 32'h01010101, 1'b1);
        wait_valid("latency_after_rst", 8);
        check_all("after_rst_c", 1, 1);
        handshake();

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
